// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard_if
//  Purpose  : Bundles every pipeline-facing signal of the hazard scoreboard.
//             The master modport is the pipeline side, which drives stage
//             fields and receives stall/forward controls. The slave modport
//             is the scoreboard side.
//  Ports    : F/D, D/X, X/M, M/W stage fields, mult/div issue, flush;
//             stall/bubble/flush controls, forward selects, mult/div
//             write-back request, stall statistics.
//  Revision : 1.0  initial release
// ============================================================================
interface hazard_scoreboard_if #(
    parameter int ADDR_W = 5,
    parameter int STAT_W = 16
);
    // F/D stage
    logic [ADDR_W-1:0] fd_rs, fd_rt, fd_rd;
    logic              fd_rs_used, fd_rt_used, fd_we, fd_is_md;
    // D/X stage
    logic [ADDR_W-1:0] dx_rs, dx_rt, dx_rd;
    logic              dx_rs_used, dx_rt_used, dx_we, dx_is_load, dx_is_md;
    // X/M and M/W stages
    logic [ADDR_W-1:0] xm_rd;
    logic              xm_we, xm_is_sw;
    logic [ADDR_W-1:0] mw_rd;
    logic              mw_we;
    // Mult/div issue and control flow
    logic              md_start;
    logic [ADDR_W-1:0] md_rd;
    logic              flush;
    // Outputs
    logic              stall_fd, bubble_dx, flush_fd;
    logic [1:0]        fwd_a_sel, fwd_b_sel;
    logic              fwd_sw;
    logic              md_busy, md_wb_valid;
    logic [ADDR_W-1:0] md_wb_rd;
    logic [STAT_W-1:0] stall_cycles;

    modport master (
        output fd_rs, fd_rt, fd_rd, fd_rs_used, fd_rt_used, fd_we, fd_is_md,
        output dx_rs, dx_rt, dx_rd, dx_rs_used, dx_rt_used, dx_we, dx_is_load, dx_is_md,
        output xm_rd, xm_we, xm_is_sw, mw_rd, mw_we, md_start, md_rd, flush,
        input  stall_fd, bubble_dx, flush_fd, fwd_a_sel, fwd_b_sel, fwd_sw,
        input  md_busy, md_wb_valid, md_wb_rd, stall_cycles
    );

    modport slave (
        input  fd_rs, fd_rt, fd_rd, fd_rs_used, fd_rt_used, fd_we, fd_is_md,
        input  dx_rs, dx_rt, dx_rd, dx_rs_used, dx_rt_used, dx_we, dx_is_load, dx_is_md,
        input  xm_rd, xm_we, xm_is_sw, mw_rd, mw_we, md_start, md_rd, flush,
        output stall_fd, bubble_dx, flush_fd, fwd_a_sel, fwd_b_sel, fwd_sw,
        output md_busy, md_wb_valid, md_wb_rd, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard
//  Purpose  : Hazard detection and forwarding for a 5-stage pipeline with a
//             multi-cycle mult/div unit. Tracks in-flight mult/div targets in
//             a per-register busy scoreboard, detects load-use, RAW/WAW and
//             structural hazards, selects ALU/store forwarding sources and
//             arbitrates the mult/div write-back against the M/W write port.
//  Ports    : clock, reset (sync, active-high); bus (slave modport) carrying
//             all stage fields and control/forward/status outputs.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int MD_LAT = 32,
    parameter int STAT_W = 16
) (
    input wire             clock,
    input wire             reset,
    hazard_scoreboard_if.slave bus
);
    localparam int              CNT_W     = 8;
    localparam logic [CNT_W-1:0] c_cntLoad = CNT_W'(MD_LAT - 2);
    localparam int              NREG      = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mdState_t;

    mdState_t          r_state, w_nextState;
    logic [CNT_W-1:0]  r_cnt, w_cntNext;
    logic [ADDR_W-1:0] r_mdRd;
    logic [NREG-1:0]   r_busy;
    logic [STAT_W-1:0] r_stallCycles;

    logic w_mdLatch, w_mdWbValid;
    logic w_pendRs, w_pendRt, w_pendRd;
    logic w_loadUse, w_sbHazard, w_structHazard, w_hazard, w_stall;

    // Forward source for one operand: X/M beats a finishing mult/div, which
    // beats M/W, because X/M holds the youngest value of the register.
    function automatic logic [1:0] fwdSel(
        input logic [ADDR_W-1:0] src,  input logic used,
        input logic              xmWe, input logic [ADDR_W-1:0] xmRd,
        input logic              wbV,  input logic [ADDR_W-1:0] wbRd,
        input logic              mwWe, input logic [ADDR_W-1:0] mwRd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (used && src != '0) begin
            if (xmWe && xmRd == src)      sel = 2'b10;
            else if (wbV && wbRd == src)  sel = 2'b11;
            else if (mwWe && mwRd == src) sel = 2'b01;
        end
        return sel;
    endfunction

    // ---------------- mult/div FSM ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mdRd  <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_cntNext;
            if (w_mdLatch) r_mdRd <= bus.md_rd;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_cntNext   = r_cnt;
        w_mdLatch   = 1'b0;
        w_mdWbValid = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.md_start) begin
                    w_nextState = RUN;
                    w_cntNext   = c_cntLoad;
                    w_mdLatch   = 1'b1;
                end
            end
            RUN: begin
                if (r_cnt == '0) w_nextState = DONE;
                else             w_cntNext   = r_cnt - 1'b1;
            end
            DONE: begin
                // The regfile has one write port; a pipeline write wins.
                if (!bus.mw_we) begin
                    w_mdWbValid = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // ---------------- busy scoreboard ----------------
    // Set and clear occur in different FSM states, so they never collide.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            if (w_mdLatch && bus.md_rd != '0) r_busy[bus.md_rd] <= 1'b1;
            if (w_mdWbValid)                  r_busy[r_mdRd]    <= 1'b0;
        end
    end

    // ---------------- hazard detection ----------------
    // The pending set also includes a mult/div sitting in D/X that has not
    // yet reached the scoreboard.
    always_comb begin
        w_pendRs = r_busy[bus.fd_rs] | (bus.dx_is_md && bus.dx_rd != '0 && bus.dx_rd == bus.fd_rs);
        w_pendRt = r_busy[bus.fd_rt] | (bus.dx_is_md && bus.dx_rd != '0 && bus.dx_rd == bus.fd_rt);
        w_pendRd = r_busy[bus.fd_rd] | (bus.dx_is_md && bus.dx_rd != '0 && bus.dx_rd == bus.fd_rd);

        w_loadUse = bus.dx_is_load && bus.dx_we && bus.dx_rd != '0 &&
                    ((bus.fd_rs_used && bus.fd_rs == bus.dx_rd) ||
                     (bus.fd_rt_used && bus.fd_rt == bus.dx_rd));

        w_sbHazard = (bus.fd_rs_used && w_pendRs) ||
                     (bus.fd_rt_used && w_pendRt) ||
                     (bus.fd_we      && w_pendRd);

        w_structHazard = bus.fd_is_md && (r_state != IDLE || bus.md_start || bus.dx_is_md);

        // DONE stalls so the write-back is not starved by new instructions.
        w_hazard = w_loadUse || w_sbHazard || w_structHazard || r_state == DONE;
        w_stall  = w_hazard && !bus.flush;
    end

    // ---------------- stall statistics ----------------
    always_ff @(posedge clock) begin
        if (reset)                         r_stallCycles <= '0;
        else if (w_stall && !(&r_stallCycles)) r_stallCycles <= r_stallCycles + 1'b1;
    end

    // ---------------- outputs ----------------
    assign bus.stall_fd     = w_stall;
    assign bus.bubble_dx    = w_hazard || bus.flush;
    assign bus.flush_fd     = bus.flush;
    assign bus.fwd_a_sel    = fwdSel(bus.dx_rs, bus.dx_rs_used, bus.xm_we, bus.xm_rd,
                                     w_mdWbValid, r_mdRd, bus.mw_we, bus.mw_rd);
    assign bus.fwd_b_sel    = fwdSel(bus.dx_rt, bus.dx_rt_used, bus.xm_we, bus.xm_rd,
                                     w_mdWbValid, r_mdRd, bus.mw_we, bus.mw_rd);
    assign bus.fwd_sw       = bus.xm_is_sw && bus.mw_we && bus.mw_rd == bus.xm_rd && bus.xm_rd != '0;
    assign bus.md_busy      = (r_state != IDLE);
    assign bus.md_wb_valid  = w_mdWbValid;
    assign bus.md_wb_rd     = r_mdRd;
    assign bus.stall_cycles = r_stallCycles;
endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register-address width (2^ADDR_W registers; register 0 hard-wired zero).
REQ-002 SHALL have parameter MD_LAT, default 32, mult/div latency in cycles (legal range 2..255).
REQ-003 SHALL have parameter STAT_W, default 16, stall-counter width.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 fd_rs, fd_rt, fd_rd  in  ADDR_W each  F/D source and destination registers; fd_rs_used, fd_rt_used, fd_we, fd_is_md  in  1 each  their qualifiers.
REQ-007 dx_rs, dx_rt, dx_rd  in  ADDR_W each; dx_rs_used, dx_rt_used, dx_we, dx_is_load, dx_is_md  in  1 each  D/X stage fields.
REQ-008 xm_rd  in  ADDR_W, xm_we  in  1, xm_is_sw  in  1  X/M destination, write enable, store flag.
REQ-009 mw_rd  in  ADDR_W, mw_we  in  1  M/W destination and write enable.
REQ-010 md_start  in  1, md_rd  in  ADDR_W  mult/div issued from X stage this cycle, with its destination.
REQ-011 flush  in  1  branch/jump taken in X stage.
REQ-012 stall_fd  out  1  hold PC and F/D latch; bubble_dx  out  1  load noop into D/X; flush_fd  out  1  load noop into F/D.
REQ-013 fwd_a_sel, fwd_b_sel  out  2 each  ALU operand source for dx_rs / dx_rt: 00 regfile, 01 M/W, 10 X/M, 11 mult/div result.
REQ-014 fwd_sw  out  1  forward M/W write data into X/M store data.
REQ-015 md_busy  out  1; md_wb_valid  out  1; md_wb_rd  out  ADDR_W  mult/div write-back request and target.
REQ-016 stall_cycles  out  STAT_W  saturating count of cycles with stall_fd=1.

Function
REQ-017 Forwarding SHALL be combinational; per operand priority X/M (xm_we, xm_rd match) > md write-back (md_wb_valid, md_wb_rd match) > M/W (mw_we, mw_rd match) > regfile; operand must be used and register nonzero, else 00.
REQ-018 fwd_sw SHALL be 1 iff xm_is_sw & mw_we & mw_rd==xm_rd & xm_rd!=0.
REQ-019 SHALL hold a busy bit per register; pending set = busy bits plus dx_rd when dx_is_md & dx_rd!=0.
REQ-020 Load-use hazard: dx_is_load & dx_we & dx_rd!=0 & used fd_rs or fd_rt equals dx_rd.
REQ-021 Scoreboard hazard: used fd_rs/fd_rt in pending set (RAW), or fd_we & fd_rd in pending set (WAW).
REQ-022 Structural hazard: fd_is_md & (state!=IDLE | md_start | dx_is_md).
REQ-023 stall_fd = bubble_dx = 1 when any of REQ-020..022 holds or state==DONE, unless flush=1.
REQ-024 flush=1 SHALL force flush_fd=1, bubble_dx=1, stall_fd=0 regardless of hazards; busy bits and mult/div state unaffected.
REQ-025 FSM states IDLE, RUN, DONE; IDLE->RUN on md_start (load counter MD_LAT-2, latch md_rd, set busy[md_rd] if nonzero); md_start outside IDLE is ignored.
REQ-026 RUN: decrement counter each cycle; at counter==0 go to DONE.
REQ-027 DONE: md_wb_valid=1 only when mw_we=0; on that cycle clear busy[md_wb_rd] and return to IDLE; otherwise remain in DONE (bubbles drain the write port within 3 cycles).
REQ-028 md_busy = (state!=IDLE); md_wb_rd = latched md_rd in all states.
REQ-029 With mw_we=0, md_wb_valid SHALL rise exactly MD_LAT cycles after the md_start cycle.
REQ-030 stall_cycles SHALL increment on each stall_fd=1 cycle and hold at 2^STAT_W-1.

Reset
REQ-031 reset=1 at a clock edge SHALL set state IDLE, counter 0, all busy bits 0, latched md_rd 0, stall_cycles 0, including mid-operation.
REQ-032 During and after reset, with all inputs 0, all outputs SHALL be 0.

Verification
REQ-033 dx: lw r3, dx_is_load=1; fd: add reads r3 -> stall_fd=1, bubble_dx=1 one cycle; next cycle fwd_a_sel=01.
REQ-034 xm_we, xm_rd=5 and mw_we, mw_rd=5; dx_rs=5 used -> fwd_a_sel=10; same with dx_rs=0 -> 00.
REQ-035 MD_LAT=4, md_start md_rd=7 at cycle 0, fd reads r7 -> stall_fd=1 cycles 1..4, md_wb_valid=1 cycle 4, busy clear, stall released cycle 5.
REQ-036 mw_we=1 on the cycle DONE is entered -> md_wb_valid delayed until first mw_we=0 cycle, stall_fd=1 throughout.
REQ-037 flush=1 coincident with load-use hazard -> flush_fd=1, bubble_dx=1, stall_fd=0, stall_cycles unchanged.
REQ-038 reset asserted in RUN -> next cycle md_busy=0, md_wb_valid=0, no stall on the former md_rd.
